// File: rtl/keypad_emulator_pkg.sv
// Shared game package: FSM encoding, key codes and counter width
// for the keypad emulator.
package keypad_emulator_pkg;

   localparam int CNT_W = 16;

   typedef enum logic [2:0] {
      ST_IDLE           = 3'd0,
      ST_BOUNCE_PRESS   = 3'd1,
      ST_HOLD           = 3'd2,
      ST_BOUNCE_RELEASE = 3'd3,
      ST_GAP            = 3'd4
   } state_e;

   localparam logic [3:0] KEY_LEFT  = 4'h1;
   localparam logic [3:0] KEY_DOWN  = 4'h2;
   localparam logic [3:0] KEY_RIGHT = 4'h3;
   localparam logic [3:0] KEY_UP    = 4'h6;

endpackage

// File: rtl/keypad_emulator_if.sv
// Press-request handshake between a key source and the emulator.
interface keypad_emulator_if;

   logic       req_valid;
   logic [3:0] req_code;
   logic       req_ready;
   logic       abort;
   logic       busy;
   logic       done;

   modport master (
      output req_valid, req_code, abort,
      input  req_ready, busy, done
   );

   modport slave (
      input  req_valid, req_code, abort,
      output req_ready, busy, done
   );

endinterface

// File: rtl/keypad_emulator_press_timer.sv
// Elapsed-cycle counter for each timed press phase; tc flags the
// final cycle of the phase.
module press_timer
   import keypad_emulator_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic [CNT_W-1:0] last,
   output logic [CNT_W-1:0] elapsed,
   output logic             tc
);

   logic [CNT_W-1:0] elapsed_q;
   logic [CNT_W-1:0] elapsed_d;

   always_comb begin
      elapsed_d = clr ? '0 : elapsed_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst) elapsed_q <= '0;
      else      elapsed_q <= elapsed_d;
   end

   assign elapsed = elapsed_q;
   assign tc      = (elapsed_q == last);

endmodule

// File: rtl/keypad_emulator.sv
// Keypad emulator: presses one matrix key with contact bounce and
// behaves like a passive switch between col strobes and row lines.
module keypad_emulator
   import keypad_emulator_pkg::*;
#(
   parameter int HOLD_CYCLES   = 1000,
   parameter int BOUNCE_CYCLES = 16,
   parameter int BOUNCE_PERIOD = 4,
   parameter int GAP_CYCLES    = 100
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  col,
   output logic [3:0]  row,
   keypad_emulator_if.slave kp
);

   localparam int PER_SH = $clog2(BOUNCE_PERIOD);

   localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] BOUNCE_LAST = CNT_W'(BOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYCLES - 1);

   // Zero-length phases are skipped entirely
   localparam state_e PRESS_ST = (BOUNCE_CYCLES > 0) ? ST_BOUNCE_PRESS
                                                     : ST_HOLD;
   localparam state_e GAP_ST   = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
   localparam state_e REL_ST   = (BOUNCE_CYCLES > 0) ? ST_BOUNCE_RELEASE
                                                     : GAP_ST;

   state_e state_q, state_d;
   logic [3:0] key_q, key_d;
   logic done_q, done_d;

   logic [CNT_W-1:0] elapsed;
   logic [CNT_W-1:0] last;
   logic tc;
   logic clr;
   logic contact;
   logic bounce_closed;

   press_timer u_timer (
      .clk     (clk),
      .rst     (rst),
      .clr     (clr),
      .last    (last),
      .elapsed (elapsed),
      .tc      (tc)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         key_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         key_q   <= key_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      key_d   = key_q;
      unique case (state_q)
         ST_IDLE: begin
            if (kp.req_valid) begin
               state_d = PRESS_ST;
               key_d   = kp.req_code;
            end
         end
         ST_BOUNCE_PRESS: begin
            if (kp.abort)   state_d = REL_ST;
            else if (tc)    state_d = ST_HOLD;
         end
         ST_HOLD: begin
            if (kp.abort || tc) state_d = REL_ST;
         end
         ST_BOUNCE_RELEASE: begin
            if (tc) state_d = GAP_ST;
         end
         ST_GAP: begin
            if (tc) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      done_d = (state_q != ST_IDLE) && (state_d == ST_IDLE);
      clr    = (state_d != state_q) || (state_q == ST_IDLE);
   end

   always_comb begin
      unique case (state_q)
         ST_BOUNCE_PRESS,
         ST_BOUNCE_RELEASE: last = BOUNCE_LAST;
         ST_HOLD:           last = HOLD_LAST;
         ST_GAP:            last = GAP_LAST;
         default:           last = '0;
      endcase
   end

   // Contact is gated by rst so a reset releases the key at once
   always_comb begin
      bounce_closed = ((elapsed >> PER_SH) & CNT_W'(1)) == '0;
      contact       = 1'b0;
      unique case (state_q)
         ST_HOLD:           contact = 1'b1;
         ST_BOUNCE_PRESS,
         ST_BOUNCE_RELEASE: contact = bounce_closed;
         default:           contact = 1'b0;
      endcase
      contact = contact && rst;
      row     = 4'hF;
      if (contact && !col[key_q[1:0]]) row[key_q[3:2]] = 1'b0;
   end

   assign kp.req_ready = (state_q == ST_IDLE) || !rst;
   assign kp.busy      = (state_q != ST_IDLE) && rst;
   assign kp.done      = done_q && rst;

endmodule

// File: doc/keypad_emulator.md
KEYPAD_EMULATOR -- requirements
Module: keypad_emulator

Interface
REQ-001 Parameter HOLD_CYCLES, default 1000, number of clk cycles the contact stays solidly closed.
REQ-002 Parameter BOUNCE_CYCLES, default 16, length in cycles of each bounce phase (press and release); 0 disables bounce.
REQ-003 Parameter BOUNCE_PERIOD, default 4, cycles per bounce half-period; power of two, minimum 1.
REQ-004 Parameter GAP_CYCLES, default 100, minimum contact-open cycles after release before the next request is accepted.
REQ-005 clk  input  1  system clock; the only clock.
REQ-006 rst  input  1  reset, synchronous and active-low.
REQ-007 col  input  4  column strobes from the keypad scanner, active-low.
REQ-008 row  output  4  row sense lines to the scanner, active-low, idle 4'hF.
REQ-009 req_valid  input  1  key-press request.
REQ-010 req_code  input  4  key to press; code = row_index*4 + col_index.
REQ-011 req_ready  output  1  high when a request can be accepted.
REQ-012 abort  input  1  forces early release of the current press.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 done  output  1  one-cycle pulse when a press sequence completes, including GAP.

Function
REQ-015 States: IDLE, BOUNCE_PRESS, HOLD, BOUNCE_RELEASE, GAP.
REQ-016 req_ready = (state == IDLE); a request is accepted on the edge where req_valid && req_ready, and req_code is latched into key_q on that edge.
REQ-017 After acceptance at edge k, the state at cycle k+1 is BOUNCE_PRESS, or HOLD if BOUNCE_CYCLES == 0.
REQ-018 Each timed state lasts exactly its parameter count: BOUNCE_PRESS and BOUNCE_RELEASE last BOUNCE_CYCLES, HOLD lasts HOLD_CYCLES, GAP lasts GAP_CYCLES.
REQ-019 The 16-bit elapsed counter clears on every state entry.
REQ-020 Transitions: BOUNCE_PRESS->HOLD->BOUNCE_RELEASE->GAP->IDLE; when BOUNCE_CYCLES == 0, HOLD goes directly to GAP.
REQ-021 Contact is closed in HOLD, and in both bounce states while (elapsed / BOUNCE_PERIOD) is even; it is open in IDLE and GAP.
REQ-022 row[r] = 0 iff contact is closed, r == key_q[3:2], and col[key_q[1:0]] == 0; otherwise row[r] = 1.
REQ-023 row is combinational from col, with zero-cycle latency, matching a passive switch.
REQ-024 abort in BOUNCE_PRESS or HOLD moves the state to BOUNCE_RELEASE (or GAP if BOUNCE_CYCLES == 0) on the next edge.
REQ-025 abort in BOUNCE_RELEASE, GAP or IDLE has no effect.
REQ-026 done is asserted in the single cycle following the last GAP cycle, coincident with the IDLE state.
REQ-027 In that IDLE cycle a new request may be accepted.
REQ-028 When GAP_CYCLES == 0, GAP is skipped and done pulses on the cycle after the release ends.
REQ-029 req_valid while not ready is ignored and is not queued.
REQ-030 req_code changes after acceptance do not affect key_q.

Reset
REQ-031 When rst is low at a clk edge: state = IDLE, elapsed = 0, key_q = 0, contact open.
REQ-032 Outputs during and after reset: row = 4'hF, req_ready = 1, busy = 0, done = 0.
REQ-033 Reset mid-press releases the contact immediately and emits no done pulse.

Structure
REQ-034 The shared game package holds the state encoding constants and the key codes Left = 4'h1, Right = 4'h3, Up = 4'h6, Down = 4'h2.
REQ-035 One sub-module, press_timer, is natural: a loadable 16-bit elapsed counter with a terminal-count flag.
REQ-036 The contact-to-row decode stays in the top module.

Verification
REQ-037 Accept Left (4'h1), BOUNCE_CYCLES = 0 -> row = 4'b1110 only while col = 4'b1101, 4'hF otherwise, for 1000 cycles; done 100 cycles later.
REQ-038 Accept Up (4'h6), defaults -> during the first 16 cycles row[1] follows col[2] only in elapsed 0-3 and 8-11; then 1000 solid cycles; then release bounce with the same pattern.
REQ-039 Assert abort at HOLD cycle 10 -> BOUNCE_RELEASE on the next edge; done arrives 16 + 100 cycles later.
REQ-040 Hold req_valid high during busy -> no second acceptance; a second request is accepted exactly on the done cycle.
REQ-041 Drive rst low during HOLD -> row = 4'hF, busy = 0, no done pulse, req_ready = 1 on the next cycle.
REQ-042 Loopback with the keypad scanner: press Down (4'h2) -> scanner reports code 4'h2 with keydown once, and releases after the press ends.
